twiddle_gen: RTL and testbench
==============================

# twiddle_gen

Parametrised FFT twiddle-factor sequencer for an N = 2^LOG2N point radix-2 FFT. Given a stage number and ordering mode at `start`, it autonomously walks all N/2 butterflies of that stage and streams one complex twiddle W_N^idx per butterfly over a valid/ready interface, with optional conjugation for inverse transforms. It sits between the FFT control FSM and the butterfly datapath, and wraps the coefficient ROM. It generalises the fixed 32-point, DIF-only, free-running twiddle address logic.

## Interface
- `WORDSIZE`, 16: twiddle component width, signed Q1.(WORDSIZE-1).
- `LOG2N`, 5: log2 of FFT size. The ROM holds N/2 = 2^(LOG2N-1) entries.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a stage; sampled only in IDLE.
- `stage_num` in 4: stage s, 0..LOG2N-1; sampled with `start`.
- `dif` in 1: 1 = decimation-in-frequency ordering, 0 = decimation-in-time; sampled with `start`.
- `inverse` in 1: 1 = output conjugate twiddles; sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until the last word is accepted.
- `tw_valid` out 1: output word valid.
- `tw_ready` in 1: downstream accepts the word when `tw_valid && tw_ready`.
- `tw_r` out WORDSIZE: cos(2π·idx/N).
- `tw_i` out WORDSIZE: -sin(2π·idx/N), or its negation when `inverse` is set.
- `tw_k` out LOG2N-1: butterfly index k of the current word.
- `tw_last` out 1: high with the word where k = N/2-1.
- `done` out 1: one-cycle pulse in the cycle after the last handshake.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on `start`. Latches `stage_num`, `dif` and `inverse`, and clears k to 0.
  - RUN issues k = 0..N/2-1, one per pipeline advance. After k = N/2-1 is issued, RUN → DRAIN.
  - DRAIN → IDLE when the `tw_last` word handshakes. `done` pulses on the next cycle.
- `start` is ignored outside IDLE.
- Twiddle index computation, with m = LOG2N-1:
  - DIF: idx = (k mod 2^(m-s)) << s.
  - DIT: idx = (k mod 2^s) << (m-s).
  - All arithmetic is unsigned, m bits wide, and the shift result is truncated to m bits.
  - Example: DIF, s = 0 gives idx = k.
- Out-of-range stage (s ≥ LOG2N): idx is forced to 0 for all k. A full N/2-word stream of W^0 = (max, 0) is still produced.
- Conjugation: `tw_i` = -rom_i, saturated. A -2^(WORDSIZE-1) input yields 2^(WORDSIZE-1)-1. `tw_r` is unchanged.
- Pipeline: two registered stages (address register, then ROM output register).
  - Global advance enable is `en = !tw_valid || tw_ready`.
  - When `en` is low, k, the address, the ROM output and the sidecar (k, last) all hold.
  - No word is ever dropped or duplicated.
- Reset in any state:
  - FSM returns to IDLE and k = 0.
  - `tw_valid`, `busy`, `done` and `tw_last` go to 0.
  - `tw_r`, `tw_i` and `tw_k` go to 0.
  - Any in-flight stream is abandoned.

## Timing
- An accepted `start` in cycle t gives:
  - `busy` = 1 from t+1.
  - First `tw_valid` in t+2.
- With `tw_ready` held high:
  - One word per cycle.
  - `tw_last` in cycle t+1+N/2.
  - `done` in t+2+N/2.
  - `busy` low from t+2+N/2.
- Back-to-back stages: `start` may be asserted in the `done` cycle. The next stage then delivers its first word 2 cycles later.
- Stalls: `tw_ready` low freezes the outputs, which stay stable while valid. Throughput resumes with no bubble on the cycle `tw_ready` returns high.
- Outputs are registered, with no combinational path from inputs to outputs. `tw_ready` only gates enables.

## Structure
- Shared package `fft_pkg` holds:
  - The FSM state encoding (IDLE, RUN, DRAIN).
  - The default `WORDSIZE` and `LOG2N`.
  - The function computing idx from (k, s, dif).
- One sub-module, `twiddle_rom`, parameterised by WORDSIZE and LOG2N:
  - N/2 entries of (cos, -sin), initialised from a generated memory file.
  - Registered read with chip-enable driven by `en`.
  - Reused by other FFT blocks.
- Index logic, FSM, sidecar pipeline and conjugation live in `twiddle_gen`.

## Test plan
All cases use LOG2N = 5 and WORDSIZE = 16.
- DIF, s = 0, ready = 1: idx 0..15. Word 0 is (0x7FFF, 0x0000) and word 8 is (0x0000, 0x8001). `tw_last` on word 15; first valid at start+2, `done` at start+18.
- DIF, s = 1: idx 0,2,4,…,14,0,2,…,14. DIT, s = 1: idx 0,8 repeating. DIT, s = 4: idx 0..15. DIF, s = 4: all 0.
- `inverse` = 1, DIF s = 0: word 8 `tw_i` = 0x7FFF and word 4 `tw_i` = +0x5A82. Full sequence conjugate of the `inverse` = 0 run.
- Random `tw_ready` pattern: exactly 16 handshakes with idx in order, and outputs stable during stalls. `start` pulses while busy are ignored.
- `rst` asserted at word 6 of a stream: the next cycle shows all outputs 0 and IDLE. A new `start` gives a clean stream from k = 0.
- `stage_num` = 7: 16 words of (0x7FFF, 0), then `done` pulses.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT definitions: sequencer states, default sizes, twiddle index and coefficient helpers
//
// Purpose: common types and elaboration-time helpers for the FFT blocks.
//   tw_state_e      : twiddle sequencer FSM encoding (IDLE, RUN, DRAIN)
//   twiddle_idx()   : twiddle index for butterfly k of stage s, DIF or DIT ordering
//   twiddle_entry() : fixed-point (cos, -sin) pair for one ROM entry, evaluated at elaboration
package fft_pkg;

   localparam int WORDSIZE_DEF = 16;
   localparam int LOG2N_DEF    = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } tw_state_e;

   // Index arithmetic is m = log2n-1 bits wide; the shift result is truncated to m bits.
   // Stages beyond the transform size collapse to W^0.
   function automatic logic [15:0] twiddle_idx(input logic [15:0] k,
                                                input logic [3:0]  s,
                                                input logic        dif,
                                                input int          log2n);
      int          m;
      int          sh;
      logic [15:0] keep;
      logic [15:0] mmask;
      logic [15:0] idx;
      m     = log2n - 1;
      mmask = 16'((32'd1 << m) - 32'd1);
      if (int'(s) >= log2n) begin
         return 16'd0;
      end
      if (dif) begin
         keep = 16'((32'd1 << (m - int'(s))) - 32'd1);
         sh   = int'(s);
      end else begin
         keep = 16'((32'd1 << int'(s)) - 32'd1);
         sh   = m - int'(s);
      end
      idx = (k & keep) << sh;
      return idx & mmask;
   endfunction

   localparam int     FRAC = 28;
   localparam longint PI_Q = 64'sd843314857;  // pi in Q28

   // Returns {32'(cos), 32'(-sin)} of 2*pi*idx/N scaled to Q1.(wordsize-1), rounded.
   // idx < N/2, so the angle is split into quadrant 0 or 1 and a reduced angle in [0, pi/2)
   // where a short Taylor series in Q28 is accurate well below one LSB.
   function automatic logic [63:0] twiddle_entry(input int idx,
                                                 input int wordsize,
                                                 input int log2n);
      longint x;
      longint x2;
      longint s_term;
      longint c_term;
      longint s_acc;
      longint c_acc;
      longint cos_v;
      longint sin_v;
      longint scale;
      longint half;
      longint q_r;
      longint q_i;
      int     quarter;
      int     q;
      int     r;
      quarter = (log2n >= 2) ? (1 << (log2n - 2)) : 1;
      q       = idx / quarter;
      r       = idx % quarter;
      x       = (64'sd2 * PI_Q * longint'(r)) >>> log2n;
      x2      = (x * x) >>> FRAC;
      s_term  = x;
      s_acc   = x;
      c_term  = 64'sd1 <<< FRAC;
      c_acc   = c_term;
      for (int n = 1; n <= 7; n++) begin
         s_term = -(((s_term * x2) >>> FRAC) / longint'((2 * n) * (2 * n + 1)));
         c_term = -(((c_term * x2) >>> FRAC) / longint'((2 * n - 1) * (2 * n)));
         s_acc  = s_acc + s_term;
         c_acc  = c_acc + c_term;
      end
      if (q == 0) begin
         cos_v = c_acc;
         sin_v = s_acc;
      end else begin
         cos_v = -s_acc;
         sin_v = c_acc;
      end
      scale = (64'sd1 <<< (wordsize - 1)) - 64'sd1;
      half  = 64'sd1 <<< (FRAC - 1);
      q_r   = (cos_v * scale + half) >>> FRAC;
      q_i   = (-sin_v * scale + half) >>> FRAC;
      if (q_r > scale)  q_r = scale;
      if (q_r < -scale) q_r = -scale;
      if (q_i > scale)  q_i = scale;
      if (q_i < -scale) q_i = -scale;
      return {q_r[31:0], q_i[31:0]};
   endfunction

endpackage

// File: rtl/twiddle_rom.sv
// rtl/twiddle_rom.sv - N/2-entry (cos, -sin) twiddle coefficient ROM with registered read
//
// Purpose: coefficient store shared by the FFT blocks; contents computed at elaboration.
// Ports:
//   clk_i   in  clock
//   rst_i   in  synchronous active-high reset, clears the read register
//   ce_i    in  read enable; the output register holds while low
//   addr_i  in  entry index 0..N/2-1
//   cos_o   out registered cos(2*pi*addr/N), signed Q1.(WORDSIZE-1)
//   nsin_o  out registered -sin(2*pi*addr/N), signed Q1.(WORDSIZE-1)
module twiddle_rom
   import fft_pkg::*;
#(
   parameter int WORDSIZE = WORDSIZE_DEF,
   parameter int LOG2N    = LOG2N_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                ce_i,
   input  logic [LOG2N-2:0]    addr_i,
   output logic [WORDSIZE-1:0] cos_o,
   output logic [WORDSIZE-1:0] nsin_o
);

   localparam int DEPTH = 1 << (LOG2N - 1);

   logic [2*WORDSIZE-1:0] table_w [DEPTH];
   logic [2*WORDSIZE-1:0] rd_q;

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      localparam logic [63:0] ENTRY = twiddle_entry(g, WORDSIZE, LOG2N);
      assign table_w[g] = {ENTRY[32 +: WORDSIZE], ENTRY[0 +: WORDSIZE]};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q <= '0;
      end else if (ce_i) begin
         rd_q <= table_w[addr_i];
      end
   end

   assign cos_o  = rd_q[2*WORDSIZE-1 -: WORDSIZE];
   assign nsin_o = rd_q[WORDSIZE-1:0];

endmodule

// File: rtl/twiddle_gen.sv
// rtl/twiddle_gen.sv - per-stage FFT twiddle sequencer streaming one W_N^idx per butterfly
//
// Purpose: on start, walks k = 0..N/2-1 for the latched stage/ordering and streams twiddles.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a stage (only honoured in IDLE)
//   stage_num, dif        stage number and ordering, latched with start
//   inverse               conjugate output twiddles, latched with start
//   busy                  stage in progress
//   tw_valid, tw_ready    output handshake
//   tw_r, tw_i            twiddle (cos, -sin), tw_i negated when inverse
//   tw_k, tw_last         butterfly index of the word, high on k = N/2-1
//   done                  one-cycle pulse after the last handshake
module twiddle_gen
   import fft_pkg::*;
#(
   parameter int WORDSIZE = WORDSIZE_DEF,
   parameter int LOG2N    = LOG2N_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [3:0]          stage_num,
   input  logic                dif,
   input  logic                inverse,
   output logic                busy,
   output logic                tw_valid,
   input  logic                tw_ready,
   output logic [WORDSIZE-1:0] tw_r,
   output logic [WORDSIZE-1:0] tw_i,
   output logic [LOG2N-2:0]    tw_k,
   output logic                tw_last,
   output logic                done
);

   localparam int M = LOG2N - 1;

   tw_state_e state_q, state_d;

   logic [M-1:0] k_q, k_d;
   logic [3:0]   s_q, s_d;
   logic         dif_q, dif_d;
   logic         inv_q, inv_d;
   // address stage
   logic [M-1:0] addr_q, addr_d;
   logic         v1_q, v1_d;
   logic [M-1:0] k1_q, k1_d;
   logic         last1_q, last1_d;
   // ROM output stage sidecar
   logic         v2_q, v2_d;
   logic [M-1:0] k2_q, k2_d;
   logic         last2_q, last2_d;
   logic         done_q, done_d;

   logic                en;
   logic                hs_last;
   logic [WORDSIZE-1:0] rom_cos;
   logic [WORDSIZE-1:0] rom_nsin;
   logic [WORDSIZE-1:0] nsin_neg;

   // Whole pipeline advances together; a stalled valid word freezes everything behind it.
   assign en      = !v2_q || tw_ready;
   assign hs_last = v2_q && tw_ready && last2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start)                state_d = ST_RUN;
         ST_RUN:   if (en && (k_q == '1))    state_d = ST_DRAIN;
         ST_DRAIN: if (hs_last)              state_d = ST_IDLE;
         default:                            state_d = ST_IDLE;
      endcase
   end

   // Word k = 0 is issued straight from IDLE so the first word appears two cycles after start;
   // RUN then issues k = 1..N/2-1. en is always high in IDLE because the stream is empty there.
   always_comb begin
      k_d     = k_q;
      s_d     = s_q;
      dif_d   = dif_q;
      inv_d   = inv_q;
      addr_d  = addr_q;
      v1_d    = v1_q;
      k1_d    = k1_q;
      last1_d = last1_q;
      v2_d    = v2_q;
      k2_d    = k2_q;
      last2_d = last2_q;
      done_d  = hs_last;
      if (en) begin
         v1_d    = 1'b0;
         last1_d = 1'b0;
         v2_d    = v1_q;
         k2_d    = k1_q;
         last2_d = last1_q;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  s_d     = stage_num;
                  dif_d   = dif;
                  inv_d   = inverse;
                  addr_d  = '0;  // idx of k = 0 is 0 for every stage and ordering
                  k1_d    = '0;
                  v1_d    = 1'b1;
                  k_d     = M'(1);
               end
            end
            ST_RUN: begin
               addr_d  = M'(twiddle_idx(16'(k_q), s_q, dif_q, LOG2N));
               k1_d    = k_q;
               last1_d = (k_q == '1);
               v1_d    = 1'b1;
               k_d     = k_q + M'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q     <= '0;
         s_q     <= '0;
         dif_q   <= 1'b0;
         inv_q   <= 1'b0;
         addr_q  <= '0;
         v1_q    <= 1'b0;
         k1_q    <= '0;
         last1_q <= 1'b0;
         v2_q    <= 1'b0;
         k2_q    <= '0;
         last2_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         k_q     <= k_d;
         s_q     <= s_d;
         dif_q   <= dif_d;
         inv_q   <= inv_d;
         addr_q  <= addr_d;
         v1_q    <= v1_d;
         k1_q    <= k1_d;
         last1_q <= last1_d;
         v2_q    <= v2_d;
         k2_q    <= k2_d;
         last2_q <= last2_d;
         done_q  <= done_d;
      end
   end

   twiddle_rom #(
      .WORDSIZE (WORDSIZE),
      .LOG2N    (LOG2N)
   ) u_rom (
      .clk_i  (clk),
      .rst_i  (rst),
      .ce_i   (en),
      .addr_i (addr_q),
      .cos_o  (rom_cos),
      .nsin_o (rom_nsin)
   );

   // Saturating negate: the most negative code has no positive twin, clamp to max.
   assign nsin_neg = (rom_nsin == {1'b1, {(WORDSIZE-1){1'b0}}})
                     ? {1'b0, {(WORDSIZE-1){1'b1}}}
                     : ({WORDSIZE{1'b0}} - rom_nsin);

   assign busy     = (state_q != ST_IDLE);
   assign tw_valid = v2_q;
   assign tw_k     = k2_q;
   assign tw_last  = last2_q;
   assign done     = done_q;
   assign tw_r     = rom_cos;
   assign tw_i     = inv_q ? nsin_neg : rom_nsin;

endmodule

// File: tb/tb_twiddle_gen.sv
// tb/tb_twiddle_gen.sv - directed self-checking bench for twiddle_gen (N = 32, 16-bit words)
module tb_twiddle_gen;

   localparam int W = 16;
   localparam int L = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [3:0]   stage_num;
   logic         dif;
   logic         inverse;
   logic         busy;
   logic         tw_valid;
   logic         tw_ready;
   logic [W-1:0] tw_r;
   logic [W-1:0] tw_i;
   logic [L-2:0] tw_k;
   logic         tw_last;
   logic         done;

   always #5 clk = ~clk;

   twiddle_gen #(.WORDSIZE(W), .LOG2N(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stage_num (stage_num),
      .dif       (dif),
      .inverse   (inverse),
      .busy      (busy),
      .tw_valid  (tw_valid),
      .tw_ready  (tw_ready),
      .tw_r      (tw_r),
      .tw_i      (tw_i),
      .tw_k      (tw_k),
      .tw_last   (tw_last),
      .done      (done)
   );

   int checks   = 0;
   int failures = 0;

   // cos and -sin of 2*pi*idx/32 in Q1.15, hand rounded
   int cos_tab [16] = '{32767, 32137, 30273, 27245, 23170, 18204, 12539, 6393,
                        0, -6393, -12539, -18204, -23170, -27245, -30273, -32137};
   int nsin_tab[16] = '{0, -6393, -12539, -18204, -23170, -27245, -30273, -32137,
                        -32767, -32137, -30273, -27245, -23170, -18204, -12539, -6393};

   logic [31:0] rdy_pat = 32'b1011_0010_1110_0110_1101_0011_1001_0111;

   logic [15:0] got_r   [64];
   logic [15:0] got_i   [64];
   logic [3:0]  got_k   [64];
   logic        got_last[64];
   int          n_words;
   int          first_valid_rel;
   int          last_rel;
   int          done_rel;
   int          done_pulses;
   int          busy_low_rel;
   int          stall_bad;
   logic        busy_at1;
   bit          timed_out;

   function automatic int exp_idx(int k, int s, bit d);
      if (s > 4) return 0;
      if (d) return ((k % (1 << (4 - s))) * (1 << s)) % 16;
      return ((k % (1 << s)) * (1 << (4 - s))) % 16;
   endfunction

   // Drives one stage and records every handshake; entered and left at #1 after a posedge.
   task automatic run_stream(input int s, input bit d, input bit inv, input int mode,
                             input bit skip_start, input bit chain);
      int          rel;
      bit          prev_stall;
      logic [15:0] pr;
      logic [15:0] pi;
      logic [3:0]  pk;
      logic        pl;
      n_words = 0; first_valid_rel = -1; last_rel = -1; done_rel = -1; done_pulses = 0;
      busy_low_rel = -1; stall_bad = 0; timed_out = 0; busy_at1 = 1'b0; prev_stall = 0;
      pr = '0; pi = '0; pk = '0; pl = 1'b0;
      tw_ready = 1'b1;
      if (!skip_start) begin
         stage_num = 4'(s); dif = d; inverse = inv; start = 1'b1;
      end
      rel = 0;
      while (1) begin
         @(posedge clk); #1;
         rel++;
         start = 1'b0;
         if (mode == 1) begin
            tw_ready = rdy_pat[rel % 32];
            if ((rel % 5 == 3) && busy) begin
               start = 1'b1; stage_num = 4'd3; dif = ~d; inverse = ~inv;
            end
         end
         if (rel == 1) busy_at1 = busy;
         if (prev_stall && (tw_r !== pr || tw_i !== pi || tw_k !== pk || tw_last !== pl || tw_valid !== 1'b1))
            stall_bad++;
         if (tw_valid && first_valid_rel < 0) first_valid_rel = rel;
         if (tw_valid && tw_ready && n_words < 64) begin
            got_r[n_words] = tw_r; got_i[n_words] = tw_i;
            got_k[n_words] = tw_k; got_last[n_words] = tw_last;
            n_words++;
            if (tw_last) last_rel = rel;
         end
         if (done) begin
            done_pulses++;
            if (done_rel < 0) done_rel = rel;
         end
         if (!busy && busy_low_rel < 0 && rel > 1) busy_low_rel = rel;
         prev_stall = tw_valid && !tw_ready;
         pr = tw_r; pi = tw_i; pk = tw_k; pl = tw_last;
         if (chain && done_rel >= 0) begin
            start = 1'b1;
            break;
         end
         if (done_rel >= 0 && rel >= done_rel + 2) break;
         if (rel > 300) begin
            timed_out = 1;
            break;
         end
      end
      if (!chain) start = 1'b0;
      tw_ready = 1'b1;
   endtask

   task automatic test_reset();
      checks++;
      if ({tw_valid, busy, done, tw_last} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b want=0000", {tw_valid, busy, done, tw_last});
      end
      checks++;
      if ({tw_r, tw_i, tw_k} !== '0) begin
         failures++;
         $display("FAIL reset_data r=%h i=%h k=%0d want all 0", tw_r, tw_i, tw_k);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (tw_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle valid=%b busy=%b want 0 0", tw_valid, busy);
      end
   endtask

   task automatic test_dif_s0();
      run_stream(0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      checks++;
      if (n_words !== 16 || timed_out) begin
         failures++; $display("FAIL dif0_count got=%0d want=16 timeout=%0d", n_words, timed_out);
      end
      checks++;
      if (got_r[0] !== 16'h7FFF || got_i[0] !== 16'h0000) begin
         failures++; $display("FAIL dif0_word0 got=(%h,%h) want=(7fff,0000)", got_r[0], got_i[0]);
      end
      checks++;
      if (got_r[8] !== 16'h0000 || got_i[8] !== 16'h8001) begin
         failures++; $display("FAIL dif0_word8 got=(%h,%h) want=(0000,8001)", got_r[8], got_i[8]);
      end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (got_r[k] !== 16'(cos_tab[k]) || got_i[k] !== 16'(nsin_tab[k]) ||
             got_k[k] !== 4'(k) || got_last[k] !== (k == 15)) begin
            failures++;
            $display("FAIL dif0_word%0d got=(%h,%h,k%0d,l%b) want=(%h,%h,k%0d,l%b)", k, got_r[k], got_i[k],
                     got_k[k], got_last[k], 16'(cos_tab[k]), 16'(nsin_tab[k]), k, (k == 15));
         end
      end
      checks++;
      if (first_valid_rel != 2 || last_rel != 17 || done_rel != 18) begin
         failures++;
         $display("FAIL dif0_timing first=%0d last=%0d done=%0d want 2 17 18", first_valid_rel, last_rel, done_rel);
      end
      checks++;
      if (busy_at1 !== 1'b1 || busy_low_rel != 18 || done_pulses != 1) begin
         failures++;
         $display("FAIL dif0_busy busy1=%b low=%0d pulses=%0d want 1 18 1", busy_at1, busy_low_rel, done_pulses);
      end
   endtask

   task automatic test_orderings();
      int cs[4] = '{1, 1, 4, 4};
      bit cd[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 4; c++) begin
         run_stream(cs[c], cd[c], 1'b0, 0, 1'b0, 1'b0);
         checks++;
         if (n_words !== 16 || done_pulses != 1) begin
            failures++;
            $display("FAIL order%0d_count got=%0d pulses=%0d want 16 1", c, n_words, done_pulses);
         end
         for (int k = 0; k < 16; k++) begin
            int idx;
            idx = exp_idx(k, cs[c], cd[c]);
            checks++;
            if (got_r[k] !== 16'(cos_tab[idx]) || got_i[k] !== 16'(nsin_tab[idx])) begin
               failures++;
               $display("FAIL order%0d_word%0d got=(%h,%h) want idx%0d=(%h,%h)", c, k, got_r[k], got_i[k],
                        idx, 16'(cos_tab[idx]), 16'(nsin_tab[idx]));
            end
         end
      end
   endtask

   task automatic test_inverse();
      run_stream(0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
      checks++;
      if (got_i[8] !== 16'h7FFF || got_i[4] !== 16'h5A82) begin
         failures++; $display("FAIL inv_words w8=%h w4=%h want 7fff 5a82", got_i[8], got_i[4]);
      end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (got_r[k] !== 16'(cos_tab[k]) || got_i[k] !== 16'(-nsin_tab[k])) begin
            failures++;
            $display("FAIL inv_word%0d got=(%h,%h) want=(%h,%h)", k, got_r[k], got_i[k],
                     16'(cos_tab[k]), 16'(-nsin_tab[k]));
         end
      end
   endtask

   task automatic test_stall_random();
      run_stream(1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
      checks++;
      if (n_words !== 16 || timed_out || done_pulses != 1) begin
         failures++;
         $display("FAIL stall_count got=%0d timeout=%0d pulses=%0d want 16 0 1", n_words, timed_out, done_pulses);
      end
      checks++;
      if (stall_bad != 0) begin
         failures++; $display("FAIL stall_stable changes=%0d want 0", stall_bad);
      end
      for (int k = 0; k < 16; k++) begin
         int idx;
         idx = exp_idx(k, 1, 1'b0);
         checks++;
         if (got_k[k] !== 4'(k) || got_r[k] !== 16'(cos_tab[idx]) || got_i[k] !== 16'(nsin_tab[idx])) begin
            failures++;
            $display("FAIL stall_word%0d got=(k%0d,%h,%h) want=(k%0d,%h,%h)", k, got_k[k], got_r[k], got_i[k],
                     k, 16'(cos_tab[idx]), 16'(nsin_tab[idx]));
         end
      end
   endtask

   task automatic test_reset_mid();
      stage_num = 4'd0; dif = 1'b1; inverse = 1'b1; tw_ready = 1'b1; start = 1'b1;
      for (int rel = 1; rel <= 8; rel++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      checks++;
      if (tw_valid !== 1'b1 || tw_k !== 4'd6) begin
         failures++; $display("FAIL rstmid_pre valid=%b k=%0d want 1 6", tw_valid, tw_k);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({tw_valid, busy, done, tw_last} !== 4'b0000 || {tw_r, tw_i, tw_k} !== '0) begin
         failures++;
         $display("FAIL rstmid_clear flags=%b r=%h i=%h k=%0d want all 0", {tw_valid, busy, done, tw_last},
                  tw_r, tw_i, tw_k);
      end
      run_stream(0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      checks++;
      if (n_words !== 16 || first_valid_rel != 2 || got_k[0] !== 4'd0 || got_i[8] !== 16'h8001) begin
         failures++;
         $display("FAIL rstmid_restart n=%0d first=%0d k0=%0d i8=%h want 16 2 0 8001", n_words,
                  first_valid_rel, got_k[0], got_i[8]);
      end
   endtask

   task automatic test_out_of_range();
      run_stream(7, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      checks++;
      if (n_words !== 16 || done_pulses != 1 || got_last[15] !== 1'b1) begin
         failures++;
         $display("FAIL oor_count n=%0d pulses=%0d last=%b want 16 1 1", n_words, done_pulses, got_last[15]);
      end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (got_r[k] !== 16'h7FFF || got_i[k] !== 16'h0000) begin
            failures++; $display("FAIL oor_word%0d got=(%h,%h) want=(7fff,0000)", k, got_r[k], got_i[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      run_stream(1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (n_words !== 16 || done_rel != 18) begin
         failures++; $display("FAIL b2b_first n=%0d done=%0d want 16 18", n_words, done_rel);
      end
      run_stream(1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      checks++;
      if (n_words !== 16 || first_valid_rel != 2 || done_rel != 18) begin
         failures++;
         $display("FAIL b2b_second n=%0d first=%0d done=%0d want 16 2 18", n_words, first_valid_rel, done_rel);
      end
      for (int k = 0; k < 16; k++) begin
         int idx;
         idx = exp_idx(k, 1, 1'b1);
         checks++;
         if (got_k[k] !== 4'(k) || got_r[k] !== 16'(cos_tab[idx])) begin
            failures++;
            $display("FAIL b2b_word%0d got=(k%0d,%h) want=(k%0d,%h)", k, got_k[k], got_r[k], k, 16'(cos_tab[idx]));
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stage_num = 4'd0; dif = 1'b0; inverse = 1'b0; tw_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_dif_s0();
      test_orderings();
      test_inverse();
      test_stall_random();
      test_reset_mid();
      test_out_of_range();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
